// File: rtl/mem_wb.sv
// mem_wb: MEM -> WB pipeline register with stall/flush handling and a
// saturating retire counter.
//
// Optional feature: define MEM_WB_HILO_EN to register the HI/LO path
// (mem_hi/mem_lo/mem_whilo -> wb_hi/wb_lo/wb_whilo). Without it those
// outputs are tied to 0, the HI/LO inputs are ignored and no HI/LO flops exist.
//
// Ports
//   clk         pipeline clock, rising edge
//   rst         asynchronous reset, active-low
//   stall[5:0]  stall vector; bit 4 = MEM held, bit 5 = WB held
//   flush       exception flush, kills the in-flight entry
//   cnt_clr     synchronous clear of retire_cnt
//   mem_*       MEM-stage result (dest reg, write enable, data, HI/LO)
//   wb_*        registered WB-stage copy of the MEM result
//   wb_valid    WB slot holds a real (non-bubble) entry
//   retire_cnt  saturating count of retired entries that write GPR or HI/LO
module mem_wb #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic [4:0]       mem_wd,
  input  logic             mem_wreg,
  input  logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_hi,
  input  logic [31:0]      mem_lo,
  input  logic             mem_whilo,
  output logic [4:0]       wb_wd,
  output logic             wb_wreg,
  output logic [31:0]      wb_wdata,
  output logic [31:0]      wb_hi,
  output logic [31:0]      wb_lo,
  output logic             wb_whilo,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } gpr_t;

  // Per-edge action decode: kill (flush or bubble), hold, or load.
  logic kill_c;
  logic load_c;
  logic retire_src_c;

  always_comb begin
    kill_c = flush | (stall[4] & ~stall[5]);
    // stall[4]=0 with stall[5]=1 is illegal and falls through to load
    load_c = ~flush & ~stall[4];
  end

  // Stall bits other than MEM/WB belong to earlier stages.
  logic unused_stall;
  assign unused_stall = ^{stall[3:0]};

  // GPR write-back payload and slot valid.
  gpr_t gpr_d, gpr_q;
  logic valid_d, valid_q;

  always_comb begin
    gpr_d   = gpr_q;
    valid_d = valid_q;
    if (kill_c) begin
      gpr_d   = '0;
      valid_d = 1'b0;
    end else if (load_c) begin
      gpr_d   = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      gpr_q   <= gpr_d;
      valid_q <= valid_d;
    end
  end

  assign wb_wd    = gpr_q.wd;
  assign wb_wreg  = gpr_q.wreg;
  assign wb_wdata = gpr_q.wdata;
  assign wb_valid = valid_q;

`ifdef MEM_WB_HILO_EN
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
  } hilo_t;

  // HI/LO write-back payload, same kill/hold/load behaviour as the GPR path.
  hilo_t hilo_d, hilo_q;

  always_comb begin
    hilo_d = hilo_q;
    if (kill_c) begin
      hilo_d = '0;
    end else if (load_c) begin
      hilo_d = '{hi: mem_hi, lo: mem_lo, whilo: mem_whilo};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  assign wb_hi        = hilo_q.hi;
  assign wb_lo        = hilo_q.lo;
  assign wb_whilo     = hilo_q.whilo;
  assign retire_src_c = mem_wreg | mem_whilo;
`else
  // HI/LO path absent: outputs constant, inputs deliberately unused.
  logic unused_hilo;
  assign unused_hilo  = ^{mem_hi, mem_lo, mem_whilo};
  assign wb_hi        = '0;
  assign wb_lo        = '0;
  assign wb_whilo     = 1'b0;
  assign retire_src_c = mem_wreg;
`endif

  // Saturating retire counter; clear wins over increment.
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (load_c && retire_src_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: randomized + directed bench for mem_wb with a behavioural model.
module tb_mem_wb;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [5:0]       stall;
  logic             flush;
  logic             cnt_clr;
  logic [4:0]       mem_wd;
  logic             mem_wreg;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_hi;
  logic [31:0]      mem_lo;
  logic             mem_whilo;
  logic [4:0]       wb_wd;
  logic             wb_wreg;
  logic [31:0]      wb_wdata;
  logic [31:0]      wb_hi;
  logic [31:0]      wb_lo;
  logic             wb_whilo;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_cnt;

  int n_checks = 0;
  int n_err    = 0;

  mem_wb #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .wb_whilo  (wb_whilo),
    .wb_valid  (wb_valid),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the WB slot is either a copy of the last accepted MEM
  // result, an empty NOP, or unchanged; the counter is a clamped integer.
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_whilo;
  logic        m_valid;
  int          m_cnt;

  task automatic model_empty();
    m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
    m_hi = '0; m_lo = '0; m_whilo = 1'b0;
    m_valid = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_empty();
      m_cnt = 0;
    end else begin
      bit accept;
      bit writes;
      accept = !flush && !stall[4];
`ifdef MEM_WB_HILO_EN
      writes = mem_wreg || mem_whilo;
`else
      writes = mem_wreg;
`endif
      if (flush) model_empty();
      else if (stall[4] && !stall[5]) model_empty();
      else if (accept) begin
        m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata; m_valid = 1'b1;
`ifdef MEM_WB_HILO_EN
        m_hi = mem_hi; m_lo = mem_lo; m_whilo = mem_whilo;
`endif
      end
      if (cnt_clr) m_cnt = 0;
      else if (accept && writes) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_wd",    32'(wb_wd),      32'(m_wd));
    chk("cmp_wreg",  32'(wb_wreg),    32'(m_wreg));
    chk("cmp_wdata", wb_wdata,        m_wdata);
    chk("cmp_hi",    wb_hi,           m_hi);
    chk("cmp_lo",    wb_lo,           m_lo);
    chk("cmp_whilo", 32'(wb_whilo),   32'(m_whilo));
    chk("cmp_valid", 32'(wb_valid),   32'(m_valid));
    chk("cmp_cnt",   32'(retire_cnt), 32'(m_cnt));
  end

  // Inputs change 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic c,
                       input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
    stall = s; flush = f; cnt_clr = c;
    mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
    mem_hi = '0; mem_lo = '0; mem_whilo = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wd"},    32'(wb_wd),    32'd0);
    chk({name, "_wreg"},  32'(wb_wreg),  32'd0);
    chk({name, "_wdata"}, wb_wdata,      32'd0);
    chk({name, "_hi"},    wb_hi,         32'd0);
    chk({name, "_lo"},    wb_lo,         32'd0);
    chk({name, "_whilo"}, 32'(wb_whilo), 32'd0);
    chk({name, "_valid"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(6'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    #2;
    chk_all_zero("reset");
    chk("reset_cnt", 32'(retire_cnt), 32'd0);
    step();
    rst = 1'b1;

    // Plain load
    drive(6'b000000, 1'b0, 1'b0, 5'd3, 1'b1, 32'h1234_5678);
    step();
    chk("load_wd",    32'(wb_wd),      32'd3);
    chk("load_wreg",  32'(wb_wreg),    32'd1);
    chk("load_wdata", wb_wdata,        32'h1234_5678);
    chk("load_valid", 32'(wb_valid),   32'd1);
    chk("load_cnt",   32'(retire_cnt), 32'd1);

    // Bubble then hold
    drive(6'b010000, 1'b0, 1'b0, 5'd9, 1'b1, 32'hDEAD_BEEF);
    step();
    chk("bubble_wreg",  32'(wb_wreg),    32'd0);
    chk("bubble_valid", 32'(wb_valid),   32'd0);
    chk("bubble_cnt",   32'(retire_cnt), 32'd1);
    drive(6'b110000, 1'b0, 1'b0, 5'd9, 1'b1, 32'hDEAD_BEEF);
    step();
    step();
    chk("hold0_valid", 32'(wb_valid),   32'd0);
    chk("hold0_wdata", wb_wdata,        32'd0);
    chk("hold0_cnt",   32'(retire_cnt), 32'd1);

    // Load then hold a real entry
    drive(6'b000000, 1'b0, 1'b0, 5'd7, 1'b1, 32'hCAFE_0007);
    step();
    drive(6'b110000, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0);
    step();
    step();
    chk("hold1_wd",    32'(wb_wd),      32'd7);
    chk("hold1_wdata", wb_wdata,        32'hCAFE_0007);
    chk("hold1_valid", 32'(wb_valid),   32'd1);
    chk("hold1_cnt",   32'(retire_cnt), 32'd2);

    // Illegal stall (WB held, MEM not) behaves as load
    drive(6'b100000, 1'b0, 1'b0, 5'd4, 1'b0, 32'h0000_0044);
    step();
    chk("illegal_wd",    32'(wb_wd),      32'd4);
    chk("illegal_valid", 32'(wb_valid),   32'd1);
    chk("illegal_cnt",   32'(retire_cnt), 32'd2);

    // Flush beats hold
    drive(6'b110000, 1'b1, 1'b0, 5'd5, 1'b1, 32'h5555_5555);
    step();
    chk_all_zero("flush");
    chk("flush_cnt", 32'(retire_cnt), 32'd2);

    // Saturation then clear
    for (int i = 0; i < 16; i++) begin
      drive(6'b000000, 1'b0, 1'b0, 5'(i), 1'b1, 32'(i));
      step();
    end
    chk("sat_cnt", 32'(retire_cnt), 32'hF);
    drive(6'b000000, 1'b0, 1'b1, 5'd2, 1'b1, 32'h2);
    step();
    chk("clr_cnt", 32'(retire_cnt), 32'd0);

    // HI/LO path
    drive(6'b000000, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    mem_whilo = 1'b1; mem_hi = 32'hAAAA_0000; mem_lo = 32'h0000_5555;
    step();
`ifdef MEM_WB_HILO_EN
    chk("hilo_hi",    wb_hi,           32'hAAAA_0000);
    chk("hilo_lo",    wb_lo,           32'h0000_5555);
    chk("hilo_whilo", 32'(wb_whilo),   32'd1);
    chk("hilo_cnt",   32'(retire_cnt), 32'd1);
`else
    chk("hilo_hi",    wb_hi,           32'd0);
    chk("hilo_lo",    wb_lo,           32'd0);
    chk("hilo_whilo", 32'(wb_whilo),   32'd0);
    chk("hilo_cnt",   32'(retire_cnt), 32'd0);
`endif

    // Asynchronous reset mid-cycle with a valid writing entry
    drive(6'b000000, 1'b0, 1'b0, 5'd12, 1'b1, 32'h0BAD_F00D);
    step();
    chk("pre_rst_wreg", 32'(wb_wreg), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_cnt", 32'(retire_cnt), 32'd0);
    step();
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      stall[3:0] = 4'($urandom);
      stall[4]   = ($urandom_range(0, 9) < 3);
      stall[5]   = 1'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      cnt_clr    = ($urandom_range(0, 39) == 0);
      mem_wd     = 5'($urandom);
      mem_wreg   = 1'($urandom);
      mem_wdata  = $urandom;
      mem_hi     = $urandom;
      mem_lo     = $urandom;
      mem_whilo  = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retire counter.
REQ-002 SHALL have port: clk  in  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have port: stall  in  6  pipeline stall vector; bit 4 = MEM held, bit 5 = WB held.
REQ-005 SHALL have port: flush  in  1  exception flush, kills the in-flight entry.
REQ-006 SHALL have port: cnt_clr  in  1  synchronous clear of the retire counter.
REQ-007 SHALL have ports: mem_wd in 5, mem_wreg in 1, mem_wdata in 32, mem_hi in 32, mem_lo in 32, mem_whilo in 1  (result of the MEM stage).
REQ-008 SHALL have ports: wb_wd out 5, wb_wreg out 1, wb_wdata out 32, wb_hi out 32, wb_lo out 32, wb_whilo out 1  (registered, to regfile and HI/LO register).
REQ-009 SHALL have port: wb_valid  out  1  WB slot holds a real (non-bubble) entry.
REQ-010 SHALL have port: retire_cnt  out  CNT_W  count of entries retired with a register or HI/LO write.

Function
REQ-011 SHALL register all wb_* outputs; latency from mem_* inputs to wb_* outputs is exactly 1 clk edge.
REQ-012 SHALL, each rising clk edge, select one action by priority: FLUSH > BUBBLE > HOLD > LOAD.
REQ-013 FLUSH (flush=1) SHALL force wb_wd=0, wb_wreg=0, wb_wdata=0, wb_hi=0, wb_lo=0, wb_whilo=0, wb_valid=0, irrespective of stall.
REQ-014 BUBBLE (stall[4]=1, stall[5]=0) SHALL load the same all-zero NOP as FLUSH, so a held MEM entry is never written twice.
REQ-015 HOLD (stall[4]=1, stall[5]=1) SHALL keep every wb_* output and wb_valid unchanged.
REQ-016 LOAD (stall[4]=0) SHALL capture all mem_* inputs into wb_* and set wb_valid=1.
REQ-017 stall[4]=0 with stall[5]=1 is illegal; SHALL be treated as LOAD.
REQ-018 retire_cnt SHALL increment by 1 on a LOAD edge where mem_wreg=1 or mem_whilo=1 (mem_whilo per REQ-026).
REQ-019 retire_cnt SHALL saturate at all-ones; no wrap-around.
REQ-020 cnt_clr=1 SHALL set retire_cnt to 0 on the edge; clear wins over simultaneous increment.
REQ-021 FLUSH, BUBBLE and HOLD edges SHALL never increment retire_cnt.
REQ-022 SHALL contain no combinational path from any input to any output.

Reset
REQ-023 rst=0 SHALL immediately, without clk, force wb_wd=0, wb_wreg=0, wb_wdata=0, wb_hi=0, wb_lo=0, wb_whilo=0, wb_valid=0, retire_cnt=0.
REQ-024 Reset asserted mid-operation SHALL discard the held entry; first edge after rst deasserts applies REQ-012 normally.
REQ-025 rst deassertion SHALL be synchronised externally; the block adds no synchroniser.

Configuration
REQ-026 With macro MEM_WB_HILO_EN defined, the HI/LO path (mem_hi, mem_lo, mem_whilo -> wb_hi, wb_lo, wb_whilo) SHALL be registered per REQ-011..REQ-018.
REQ-027 Without MEM_WB_HILO_EN, wb_hi, wb_lo and wb_whilo SHALL be constant 0, the HI/LO inputs SHALL be ignored (retire_cnt counts on mem_wreg only), and no HI/LO flops SHALL be synthesised.

Verification
REQ-028 Reset: drive rst=0 mid-cycle with wb_wreg=1 -> all outputs 0 before next edge, retire_cnt=0.
REQ-029 Load: stall=0, mem_wd=5'd3, mem_wreg=1, mem_wdata=32'h1234_5678 -> next edge wb_wd=3, wb_wreg=1, wb_wdata=32'h1234_5678, wb_valid=1, retire_cnt +1.
REQ-030 Bubble/hold: after load, stall=6'b010000 one cycle -> wb_wreg=0, wb_valid=0; then stall=6'b110000 two cycles -> outputs unchanged, retire_cnt unchanged.
REQ-031 Flush priority: flush=1 with stall=6'b110000 and valid entry -> next edge all wb_* 0, wb_valid=0.
REQ-032 Counter: preload retire_cnt to all-ones via CNT_W=4 and 16 retiring loads -> stays 4'hF; cnt_clr=1 with retiring load -> 0.
REQ-033 HI/LO: with MEM_WB_HILO_EN, mem_whilo=1, mem_hi=32'hAAAA_0000, mem_lo=32'h0000_5555 -> wb_hi/wb_lo match after one edge; without macro -> wb_hi=wb_lo=0, wb_whilo=0.
